// File: rtl/rff_reset_gen.sv
// Reset generator for the async-reset flop cells: immediate assertion, synchronized + held release,
// soft reset requests, and a one-cycle done strobe. Optional macro RFF_NEGEDGE_RELEASE_EN retimes release to negedge.
`timescale 1ns/1ps

module rff_reset_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_rst_req,
    output logic rst_out,
    output logic busy,
    output logic rst_done
);

    // state | meaning
    // SYNC  | board reset released, waiting for the release synchronizer to fill
    // HOLD  | rst_out held high while the hold counter runs down
    // RUN   | reset released, downstream cells running
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    logic                   r_rst_pos;
    logic                   r_busy;
    logic                   r_done;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SYNC: begin
                if (w_sync_out) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LP_LOAD;
                end
            end
            ST_HOLD: begin
                // A request during HOLD restarts the full hold period
                if (sw_rst_req) begin
                    w_cnt_nxt = LP_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LP_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_SYNC;
            r_cnt     <= '0;
            r_rst_pos <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_pos <= (w_state_nxt != ST_RUN);
            r_busy    <= (w_state_nxt != ST_RUN);
            r_done    <= (r_state == ST_HOLD) && (w_state_nxt == ST_RUN);
        end
    end

    assign rst_done = r_done;

`ifdef RFF_NEGEDGE_RELEASE_EN
    logic r_rst_neg;

    // Release lands half a cycle late; assertion still comes through r_rst_pos at once
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_neg <= 1'b1;
        end else begin
            r_rst_neg <= r_rst_pos;
        end
    end

    assign rst_out = r_rst_pos | r_rst_neg;
    assign busy    = r_busy | r_rst_neg;
`else
    assign rst_out = r_rst_pos;
    assign busy    = r_busy;
`endif

endmodule

// File: tb/tb_rff_reset_gen.sv
// Directed bench for rff_reset_gen: power-up, soft reset, hold extension, async abort, and
// a SYNC_STAGES=3 / HOLD_CYCLES=1 instance. Honours RFF_NEGEDGE_RELEASE_EN when defined.
`timescale 1ns/1ps

module tb_rff_reset_gen;

    logic clk = 1'b0;
    logic reset;
    logic sw_rst_req;
    logic rst_out;
    logic busy;
    logic rst_done;
    logic reset2;
    logic sw2;
    logic rst_out2;
    logic busy2;
    logic rst_done2;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    rff_reset_gen dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .busy       (busy),
        .rst_done   (rst_done)
    );

    rff_reset_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .CNT_W(8)) dut2 (
        .clk        (clk),
        .reset      (reset2),
        .sw_rst_req (sw2),
        .rst_out    (rst_out2),
        .busy       (busy2),
        .rst_done   (rst_done2)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges from now: n-1 with reset still held, release on the n-th, then done clears
    task automatic expect_release(input string tag, input int n);
        for (int i = 1; i < n; i++) begin
            step();
            chk({tag, "_hold_rst"}, rst_out, 1'b1);
            chk({tag, "_hold_busy"}, busy, 1'b1);
            chk({tag, "_hold_done"}, rst_done, 1'b0);
        end
        step();
        chk({tag, "_rel_done"}, rst_done, 1'b1);
`ifdef RFF_NEGEDGE_RELEASE_EN
        chk({tag, "_rel_rst_pre_neg"}, rst_out, 1'b1);
        @(negedge clk);
        #1;
        chk({tag, "_rel_rst_neg"}, rst_out, 1'b0);
        chk({tag, "_rel_busy_neg"}, busy, 1'b0);
        chk({tag, "_rel_done_neg"}, rst_done, 1'b1);
`else
        chk({tag, "_rel_rst"}, rst_out, 1'b0);
        chk({tag, "_rel_busy"}, busy, 1'b0);
`endif
        step();
        chk({tag, "_post_done"}, rst_done, 1'b0);
        chk({tag, "_post_rst"}, rst_out, 1'b0);
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("sw_assert_rst", rst_out, 1'b1);
        chk("sw_assert_busy", busy, 1'b1);
        chk("sw_assert_done", rst_done, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        sw_rst_req = 1'b0;
        reset2     = 1'b0;
        sw2        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_rst", rst_out, 1'b1);
        chk("por_busy", busy, 1'b1);
        chk("por_done", rst_done, 1'b0);
        chk("por2_rst", rst_out2, 1'b1);
        reset = 1'b1;
        expect_release("pwr", 11);

        step();
        step();
        pulse_sw();
        expect_release("soft", 8);

        step();
        pulse_sw();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ext_mid_rst", rst_out, 1'b1);
            chk("ext_mid_done", rst_done, 1'b0);
        end
        pulse_sw();
        expect_release("ext", 8);

        // Abort from RUN: rst_out must rise with no clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("abort_run_rst", rst_out, 1'b1);
        chk("abort_run_busy", busy, 1'b1);
        repeat (2) step();
        reset = 1'b1;
        expect_release("rerun", 11);

        // Abort during HOLD with counter at 4 (after edge 6)
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (6) step();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_hold_rst", rst_out, 1'b1);
        chk("abort_hold_busy", busy, 1'b1);
        chk("abort_hold_done", rst_done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_low_done", rst_done, 1'b0);
            chk("abort_low_rst", rst_out, 1'b1);
        end
        reset = 1'b1;
        expect_release("abort", 11);

        // SYNC_STAGES=3, HOLD_CYCLES=1, soft request held through SYNC
        reset2 = 1'b1;
        sw2    = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("b2_sync_rst", rst_out2, 1'b1);
            chk("b2_sync_busy", busy2, 1'b1);
            chk("b2_sync_done", rst_done2, 1'b0);
        end
        sw2 = 1'b0;
        step();
        chk("b2_rel_done", rst_done2, 1'b1);
`ifdef RFF_NEGEDGE_RELEASE_EN
        chk("b2_rel_rst_pre_neg", rst_out2, 1'b1);
        @(negedge clk);
        #1;
`endif
        chk("b2_rel_rst", rst_out2, 1'b0);
        chk("b2_rel_busy", busy2, 1'b0);
        step();
        chk("b2_post_done", rst_done2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
